// File: rtl/eth_phy_10g_pkg.sv
// rtl/eth_phy_10g_pkg.sv - shared constants, aligner state enum and sync-header helper for the 10GBASE-R PCS
package eth_phy_10g_pkg;

    localparam int BLOCK_W         = 66;
    localparam int OFFSET_W        = 7;
    localparam int LOCK_CNT_DEF    = 64;
    localparam int INVALID_MAX_DEF = 16;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } align_state_t;

    function automatic logic sync_valid(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/eth_phy_10g_rx_slip_mux.sv
// rtl/eth_phy_10g_rx_slip_mux.sv - combinational 2*BW-to-BW barrel selector picking the candidate block at a bit offset
module eth_phy_10g_rx_slip_mux
    import eth_phy_10g_pkg::*;
#(
    parameter int BW = BLOCK_W
) (
    input  logic [2*BW-1:0]   window,
    input  logic [OFFSET_W-1:0] offset,
    output logic [BW-1:0]     block
);

    // Offsets outside 0..BW-1 never occur; they select all-zero.
    always_comb begin
        block = '0;
        for (int i = 0; i < BW; i++) begin
            if (offset == OFFSET_W'(i)) begin
                block = window[i +: BW];
            end
        end
    end

endmodule

// File: rtl/eth_phy_10g_rx_block_aligner.sv
// rtl/eth_phy_10g_rx_block_aligner.sv - 64b/66b block lock aligner; ETH_PHY_RX_ALIGNER_DEBUG_EN adds slip_offset/slip ports
module eth_phy_10g_rx_block_aligner
    import eth_phy_10g_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int HDR_WIDTH   = 2,
    parameter int LOCK_CNT    = LOCK_CNT_DEF,
    parameter int INVALID_MAX = INVALID_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [HDR_WIDTH-1:0]  serdes_rx_hdr,
    input  logic [DATA_WIDTH-1:0] serdes_rx_data,
    output logic [HDR_WIDTH-1:0]  serdes_rx_hdr_align,
    output logic [DATA_WIDTH-1:0] serdes_rx_data_align,
`ifdef ETH_PHY_RX_ALIGNER_DEBUG_EN
    output logic [OFFSET_W-1:0]   slip_offset,
    output logic                  slip,
`endif
    output logic                  aligned
);

    localparam int BW    = DATA_WIDTH + HDR_WIDTH;
    localparam int SH_W  = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam int INV_W = (INVALID_MAX > 1) ? $clog2(INVALID_MAX) : 1;

    localparam logic [SH_W-1:0]     SH_LAST  = SH_W'(LOCK_CNT - 1);
    localparam logic [INV_W-1:0]    INV_LAST = INV_W'(INVALID_MAX - 1);
    localparam logic [OFFSET_W-1:0] OFF_LAST = OFFSET_W'(BW - 1);

    align_state_t          state;
    logic [BW-1:0]         raw;
    logic [BW-1:0]         prev;
    logic [BW-1:0]         cand;
    logic [OFFSET_W-1:0]   offset;
    logic [OFFSET_W-1:0]   next_offset;
    logic [SH_W-1:0]       sh_cnt;
    logic [INV_W-1:0]      inv_cnt;
    logic                  hv;
    logic                  slip_event;

    assign raw = {serdes_rx_data, serdes_rx_hdr};

    eth_phy_10g_rx_slip_mux #(
        .BW(BW)
    ) u_slip_mux (
        .window(({raw, prev})),
        .offset(offset),
        .block (cand)
    );

    assign hv          = sync_valid(cand[1:0]);
    assign next_offset = (offset == OFF_LAST) ? '0 : offset + OFFSET_W'(1);

    // Loss of lock outranks the end-of-window counter clear.
    always_comb begin
        slip_event = 1'b0;
        if (state == HUNT) begin
            slip_event = !hv;
        end else begin
            slip_event = !hv && (inv_cnt == INV_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev                 <= '0;
            offset               <= '0;
            sh_cnt               <= '0;
            inv_cnt              <= '0;
            state                <= HUNT;
            aligned              <= 1'b0;
            serdes_rx_hdr_align  <= '0;
            serdes_rx_data_align <= '0;
        end else begin
            prev                 <= raw;
            serdes_rx_hdr_align  <= cand[HDR_WIDTH-1:0];
            serdes_rx_data_align <= cand[BW-1:HDR_WIDTH];
            if (slip_event) begin
                offset <= next_offset;
            end
            case (state)
                HUNT: begin
                    if (slip_event) begin
                        sh_cnt  <= '0;
                        inv_cnt <= '0;
                    end else if (sh_cnt == SH_LAST) begin
                        state   <= LOCK;
                        aligned <= 1'b1;
                        sh_cnt  <= '0;
                        inv_cnt <= '0;
                    end else begin
                        sh_cnt <= sh_cnt + SH_W'(1);
                    end
                end
                LOCK: begin
                    if (slip_event) begin
                        state   <= HUNT;
                        aligned <= 1'b0;
                        sh_cnt  <= '0;
                        inv_cnt <= '0;
                    end else if (sh_cnt == SH_LAST) begin
                        sh_cnt  <= '0;
                        inv_cnt <= '0;
                    end else begin
                        sh_cnt <= sh_cnt + SH_W'(1);
                        if (!hv) begin
                            inv_cnt <= inv_cnt + INV_W'(1);
                        end
                    end
                end
                default: begin
                    state   <= HUNT;
                    aligned <= 1'b0;
                end
            endcase
        end
    end

`ifdef ETH_PHY_RX_ALIGNER_DEBUG_EN
    assign slip_offset = offset;

    always_ff @(posedge clk) begin
        if (rst) begin
            slip <= 1'b0;
        end else begin
            slip <= slip_event;
        end
    end
`endif

endmodule

// File: tb/tb_eth_phy_10g_rx_block_aligner.sv
// tb/tb_eth_phy_10g_rx_block_aligner.sv - randomized self-checking bench with a behavioural block-lock model
module tb_eth_phy_10g_rx_block_aligner;

    localparam int LOCK_CNT    = 64;
    localparam int INVALID_MAX = 16;
    localparam logic [65:0] CONST_W = {64'hFFFFFFFF7FFFFFFF, 2'b11};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  serdes_rx_hdr = '0;
    logic [63:0] serdes_rx_data = '0;
    logic [1:0]  serdes_rx_hdr_align;
    logic [63:0] serdes_rx_data_align;
    logic        aligned;
`ifdef ETH_PHY_RX_ALIGNER_DEBUG_EN
    logic [6:0]  slip_offset;
    logic        slip;
`endif

    eth_phy_10g_rx_block_aligner dut (
        .clk                 (clk),
        .rst                 (rst),
        .serdes_rx_hdr       (serdes_rx_hdr),
        .serdes_rx_data      (serdes_rx_data),
        .serdes_rx_hdr_align (serdes_rx_hdr_align),
        .serdes_rx_data_align(serdes_rx_data_align),
`ifdef ETH_PHY_RX_ALIGNER_DEBUG_EN
        .slip_offset         (slip_offset),
        .slip                (slip),
`endif
        .aligned             (aligned)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;
    int n        = 0;

    // Reference model: bit offset, lock flag, run of good headers, window fill and bad count.
    logic [65:0] m_prev = '0;
    int          m_off = 0;
    bit          m_locked = 0;
    int          m_good = 0;
    int          m_seen = 0;
    int          m_bad = 0;
    logic [65:0] exp_out = '0;
    bit          exp_slip = 0;

    int          dly = 0;
    bit          const_mode = 0;
    bit          hdr_tog = 0;
    bit [65:0]   blk [4096];
    int          lock_edge = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, n);
        end
    endtask

    task automatic model_slip();
        m_off    = (m_off + 1) % 66;
        exp_slip = 1;
    endtask

    task automatic tick(input logic [65:0] w, input bit r);
        logic [131:0] win;
        logic [65:0]  cand;
        bit           ok;
        serdes_rx_hdr  = w[1:0];
        serdes_rx_data = w[65:2];
        rst            = r;
        exp_slip       = 0;
        if (r) begin
            m_prev = '0; m_off = 0; m_locked = 0;
            m_good = 0; m_seen = 0; m_bad = 0; exp_out = '0;
        end else begin
            win     = {w, m_prev};
            cand    = 66'(win >> m_off);
            ok      = (cand[1:0] == 2'b01) || (cand[1:0] == 2'b10);
            exp_out = cand;
            if (!m_locked) begin
                if (ok) begin
                    m_good++;
                    if (m_good == LOCK_CNT) begin
                        m_locked = 1;
                        m_good   = 0;
                    end
                end else begin
                    m_good = 0;
                    model_slip();
                end
            end else begin
                m_seen++;
                if (!ok) m_bad++;
                if (m_bad == INVALID_MAX) begin
                    m_locked = 0; m_seen = 0; m_bad = 0;
                    model_slip();
                end else if (m_seen == LOCK_CNT) begin
                    m_seen = 0; m_bad = 0;
                end
            end
            m_prev = w;
        end
        @(posedge clk);
        #1;
        chk("hdr",     128'(serdes_rx_hdr_align),  128'(exp_out[1:0]));
        chk("data",    128'(serdes_rx_data_align), 128'(exp_out[65:2]));
        chk("aligned", 128'(aligned),              128'(m_locked));
        chk("offset",  128'(dut.offset),           128'(m_off));
`ifdef ETH_PHY_RX_ALIGNER_DEBUG_EN
        chk("slip_offset", 128'(slip_offset), 128'(m_off));
        chk("slip",        128'(slip),        128'(exp_slip));
`endif
        n++;
    endtask

    // Transmit block n, then present it to the DUT delayed by dly bits in the serial stream.
    task automatic feed(input bit corrupt, input bit r);
        bit [65:0]   b;
        bit [131:0]  pair;
        logic [65:0] raw;
        hdr_tog = !hdr_tog;
        b = {{$urandom, $urandom}, corrupt ? 2'b00 : (hdr_tog ? 2'b01 : 2'b10)};
        blk[n % 4096] = b;
        pair = {b, blk[(n + 4095) % 4096]};
        if (const_mode)    raw = CONST_W;
        else if (dly == 0) raw = b;
        else               raw = 66'(pair >> (66 - dly));
        tick(raw, r);
    endtask

    task automatic run_to_lock(input string tag, input int exp_slips, input int exp_off);
        int slips = 0;
        int since = 0;
        int last_off;
        bit got = 0;
        last_off = int'(dut.offset);
        for (int i = 0; i < 3000 && !got; i++) begin
            feed(0, 0);
            if (int'(dut.offset) != last_off) begin
                slips++;
                since    = 0;
                last_off = int'(dut.offset);
            end else begin
                since++;
            end
            if (aligned) got = 1;
        end
        lock_edge = n - 1;
        chk({tag, "_locked"},   128'(got),        128'(1));
        chk({tag, "_slips"},    128'(slips),      128'(exp_slips));
        chk({tag, "_latency"},  128'(since),      128'(LOCK_CNT));
        chk({tag, "_offset"},   128'(dut.offset), 128'(exp_off));
    endtask

    task automatic passthrough(input string tag);
        for (int i = 0; i < 20; i++) begin
            feed(0, 0);
            chk(tag, 128'({serdes_rx_data_align, serdes_rx_hdr_align}), 128'(blk[(n + 4094) % 4096]));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at edge %0d", n);
        $fatal(1);
    end

    initial begin
        bit          dropped;
        logic [131:0] cc;

        repeat (50) feed(0, 1);
        chk("rst_aligned", 128'(aligned),              128'(0));
        chk("rst_hdr",     128'(serdes_rx_hdr_align),  128'(0));
        chk("rst_data",    128'(serdes_rx_data_align), 128'(0));
        chk("rst_offset",  128'(dut.offset),           128'(0));

        // The all-zero history right after reset forces one slip, so offset 0 is reached by wrapping.
        dly = 0;
        run_to_lock("pre", 66, 0);
        passthrough("pre_out");

        repeat (3) feed(0, 1);
        dly = 17;
        run_to_lock("rot17", 17, 17);
        passthrough("rot_out");

        while ((n - lock_edge) % LOCK_CNT != 0) feed(0, 0);
        dropped = 0;
        for (int i = 0; i < 65; i++) begin
            feed(i < 15, 0);
            if (!aligned) dropped = 1;
        end
        chk("inv15_hold", 128'(dropped), 128'(0));

        while ((n - lock_edge) % LOCK_CNT != 0) feed(0, 0);
        for (int i = 0; i <= 16; i++) begin
            feed(i < 16, 0);
            if (i < 16) begin
                chk("inv16_pre", 128'(aligned), 128'(1));
            end else begin
                chk("inv16_drop",   128'(aligned),    128'(0));
                chk("inv16_offset", 128'(dut.offset), 128'(18));
            end
        end
        run_to_lock("relock", 65, 17);

        feed(0, 1);
        chk("rst_mid_aligned", 128'(aligned),    128'(0));
        chk("rst_mid_offset",  128'(dut.offset), 128'(0));
        run_to_lock("rst_relock", 17, 17);
        passthrough("rst_out");

        repeat (2) feed(0, 1);
        const_mode = 1;
        run_to_lock("const", 32, 32);
        cc = {CONST_W, CONST_W} >> 32;
        chk("const_hdr",  128'(serdes_rx_hdr_align),  128'(2'b01));
        chk("const_data", 128'(serdes_rx_data_align), 128'(cc[65:2]));

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
